// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared encodings for the iterative multiply/divide unit:
//               operation codes, FSM state encoding and divide-by-zero
//               quotient constant, plus small op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Operation encodings presented on op_i together with start_i
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MD_WIDTH = 32;

  // Quotient reported when the divisor is zero
  localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;

  // Divide operations have op[1] set
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed operations (MULT, DIV) have op[0] clear
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Combinational conditional two's-complement negation of a
//               HI/LO pair. In independent mode each half is negated on its
//               own control; in joint mode the pair is treated as a single
//               2*WIDTH value and negated as a whole under neg_lo_i.
//               Used for operand absolute values and for the final sign fix.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             joint_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] w_pair;
  logic [2*WIDTH-1:0] w_pair_neg;

  assign w_pair     = {hi_i, lo_i};
  assign w_pair_neg = ~w_pair + {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Select joint 2*WIDTH negation or per-half negation
  always_comb begin
    hi_o = neg_hi_i ? (~hi_i + {{(WIDTH-1){1'b0}}, 1'b1}) : hi_i;
    lo_o = neg_lo_i ? (~lo_i + {{(WIDTH-1){1'b0}}, 1'b1}) : lo_i;
    if (joint_i) begin
      hi_o = neg_lo_i ? w_pair_neg[2*WIDTH-1:WIDTH] : hi_i;
      lo_o = neg_lo_i ? w_pair_neg[WIDTH-1:0]       : lo_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO
//               registers. Unsigned shift-add multiply and restoring divide
//               run one bit per cycle on operand magnitudes; a single FIX
//               cycle restores signs and loads HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Sequencer and datapath registers
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;     // {acc, multiplier} or {rem, quotient}
  logic [WIDTH-1:0]   dvd_q, dvd_d;       // raw dividend for divide-by-zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand entry: magnitudes of the forwarded operands
  logic             w_in_signed;
  logic             w_in_div;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;

  assign w_in_signed = op_is_signed(op_i);
  assign w_in_div    = op_is_div(op_i);

  muldiv_signfix #(.WIDTH(WIDTH)) u_entry_fix (
    .hi_i     (data1_i),
    .lo_i     (data2_i),
    .joint_i  (1'b0),
    .neg_hi_i (w_in_signed & data1_i[WIDTH-1]),
    .neg_lo_i (w_in_signed & data2_i[WIDTH-1]),
    .hi_o     (w_mag1),
    .lo_o     (w_mag2)
  );

  // Multiply step: conditionally add multiplicand to upper half, shift right
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_step;

  assign w_add      = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign w_mul_step = {w_add, prod_q[WIDTH-1:1]};

  // Divide step: shift {rem, quotient} left, trial-subtract the divisor
  logic [2*WIDTH:0]   w_shl;
  logic [WIDTH:0]     w_rem_part;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_div_step;

  assign w_shl      = {prod_q, 1'b0};
  assign w_rem_part = w_shl[2*WIDTH:WIDTH];
  assign w_rem_ge   = (w_rem_part >= {1'b0, opnd_q});
  assign w_rem_sub  = w_rem_part[WIDTH-1:0] - opnd_q;
  assign w_div_step = w_rem_ge ? {w_rem_sub, w_shl[WIDTH-1:1], 1'b1}
                               : {w_rem_part[WIDTH-1:0], w_shl[WIDTH-1:0]};

  // FIX stage: restore signs on the unsigned core result
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_fix_neg_hi;
  logic             w_fix_neg_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_is_div     = op_is_div(op_q);
  assign w_is_signed  = op_is_signed(op_q);
  // Remainder follows the dividend; quotient/product follow the sign xor
  assign w_fix_neg_hi = w_is_signed & (w_is_div ? sign1_q : (sign1_q ^ sign2_q));
  assign w_fix_neg_lo = w_is_signed & (sign1_q ^ sign2_q);

  muldiv_signfix #(.WIDTH(WIDTH)) u_result_fix (
    .hi_i     (prod_q[2*WIDTH-1:WIDTH]),
    .lo_i     (prod_q[WIDTH-1:0]),
    .joint_i  (~w_is_div),
    .neg_hi_i (w_fix_neg_hi),
    .neg_lo_i (w_fix_neg_lo),
    .hi_o     (w_fix_hi),
    .lo_o     (w_fix_lo)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    dvd_d   = dvd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_CALC;
          count_d = '0;
          op_d    = op_i;
          sign1_d = data1_i[WIDTH-1];
          sign2_d = data2_i[WIDTH-1];
          dvd_d   = data1_i;
          opnd_d  = w_in_div ? w_mag2 : w_mag1;
          prod_d  = {{WIDTH{1'b0}}, (w_in_div ? w_mag1 : w_mag2)};
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        prod_d  = w_is_div ? w_div_step : w_mul_step;
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (w_is_div && (opnd_q == {WIDTH{1'b0}})) begin
          hi_d = dvd_q;
          lo_d = DIV0_QUOT[WIDTH-1:0];
        end else begin
          hi_d = w_fix_hi;
          lo_d = w_fix_lo;
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      dvd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      dvd_q   <= dvd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status decoded from registered state only
  assign busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done_o = (state_q == ST_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed vector bench for muldiv_unit: exact latency,
//               signed/unsigned results, divide-by-zero, overflow, ignored
//               mid-flight starts, back-to-back starts and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; leaves start high for exactly one rising edge
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    data1_i = a;
    data2_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Entered at negedge of T+1; checks busy for T+1..T+33 and result at T+34
  task automatic wait_result(input string nm, input logic [31:0] eh, input logic [31:0] el,
                             input bit glitch);
    int bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (!(busy_o === 1'b1 && done_o === 1'b0)) bad++;
      if (glitch && i == 9) begin
        start_i = 1'b1;
        op_i    = OP_DIVU;
        data1_i = 32'd1000;
        data2_i = 32'd3;
      end
      if (glitch && i == 10) start_i = 1'b0;
      @(negedge clk_i);
    end
    check({nm, "_busy_window_bad_cycles"}, 32'(bad), 32'd0);
    check({nm, "_done"}, {31'd0, done_o}, 32'd1);
    check({nm, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
    check({nm, "_hi"}, hi_o, eh);
    check({nm, "_lo"}, lo_o, el);
  endtask

  // Bounded wait for done_o, then compare HI/LO
  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    start_op(v.op, v.a, v.b);
    while (done_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check($sformatf("vec%0d_done_timeout", idx), {31'd0, done_o}, 32'd1);
    check($sformatf("vec%0d_hi", idx), hi_o, v.hi);
    check($sformatf("vec%0d_lo", idx), lo_o, v.lo);
  endtask

  vec_t vecs [10];

  initial begin
    int pulses;

    vecs[0] = '{OP_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    rst_i   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    data1_i = '0;
    data2_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Exact latency on the largest unsigned product
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(negedge clk_i);
    check("multu_max_done_drops", {31'd0, done_o}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Start issued mid-CALC must be ignored
    start_op(OP_MULTU, 32'd6, 32'd7);
    wait_result("ignored_start", 32'd0, 32'd42, 1'b1);

    // Start in the DONE cycle begins a new op immediately
    start_op(OP_DIVU, 32'd100, 32'd7);
    check("b2b_busy_next", {31'd0, busy_o}, 32'd1);
    check("b2b_done_drop", {31'd0, done_o}, 32'd0);
    wait_result("b2b", 32'd2, 32'd14, 1'b0);

    // Reset mid-operation discards the result and clears HI/LO
    start_op(OP_MULTU, 32'd6, 32'd7);
    repeat (13) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    rst_i = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o === 1'b1) pulses++;
    end
    check("midrst_no_done_pulse", 32'(pulses), 32'd0);
    check("midrst_lo_held", lo_o, 32'd0);

    start_op(OP_MULT, 32'hFFFFFFF9, 32'd3);
    wait_result("after_reset", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
